// File: rtl/operand_stack.sv
// Operand stack for the bytecode datapath: TOS/NOS in registers, deeper entries in an array.
// Latency: one command per clk, new state visible the cycle after; operand_a/operand_b are combinational from registers.
// Backpressure: none; illegal commands (underflow/overflow) are dropped and raise a sticky err.
module operand_stack #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cmd,
    input  logic          unary,
    input  logic [31:0]   data_in,
    input  logic [31:0]   result_in,
    output logic [31:0]   operand_a,
    output logic [31:0]   operand_b,
    output logic [31:0]   tos,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          err
);

    // Command encodings
    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_PUSH  = 3'b001;
    localparam logic [2:0] CMD_POP   = 3'b010;
    localparam logic [2:0] CMD_BINOP = 3'b011;
    localparam logic [2:0] CMD_UNOP  = 3'b100;
    localparam logic [2:0] CMD_DUP   = 3'b101;
    localparam logic [2:0] CMD_SWAP  = 3'b110;

    // Count constants at the count width, so all compares stay width-matched
    localparam logic [CW-1:0] C0   = '0;
    localparam logic [CW-1:0] C1   = CW'(1);
    localparam logic [CW-1:0] C2   = CW'(2);
    localparam logic [CW-1:0] CMAX = CW'(DEPTH);

    // Entries below NOS: the array holds at most DEPTH-2 values
    localparam int NDEEP = DEPTH - 2;

    logic [31:0]   tos_q;
    logic [31:0]   nos_q;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic [31:0]   deep_q [NDEEP];

    logic [31:0]   tos_d;
    logic [31:0]   nos_d;
    logic [CW-1:0] count_d;
    logic          err_set;
    logic          spill;       // NOS moves down into the array (push-like)
    logic          fill;        // top array entry moves up into NOS (pop-like)
    logic [31:0]   deep_top;    // array entry directly below NOS, 0 if none
    logic          is_empty;
    logic          is_full;

    assign is_empty = (count_q == C0);
    assign is_full  = (count_q == CMAX);

    // Select the array entry just below NOS; stays 0 when count < 3 so refills clear NOS
    always_comb begin
        deep_top = '0;
        for (int i = 0; i < NDEEP; i++) begin
            if (count_q == CW'(i + 3)) begin
                deep_top = deep_q[i];
            end
        end
    end

    // Decode the command into next-state values; illegal commands keep state and flag err
    always_comb begin
        tos_d   = tos_q;
        nos_d   = nos_q;
        count_d = count_q;
        err_set = 1'b0;
        spill   = 1'b0;
        fill    = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                if (!is_full) begin
                    tos_d   = data_in;
                    nos_d   = tos_q;
                    spill   = (count_q >= C2);
                    count_d = count_q + C1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_POP: begin
                if (!is_empty) begin
                    tos_d   = nos_q;
                    nos_d   = deep_top;
                    fill    = 1'b1;
                    count_d = count_q - C1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_BINOP: begin
                // value1 = NOS, value2 = TOS; both consumed, result replaces them
                if (count_q >= C2) begin
                    tos_d   = result_in;
                    nos_d   = deep_top;
                    fill    = 1'b1;
                    count_d = count_q - C1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_UNOP: begin
                if (!is_empty) begin
                    tos_d = result_in;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_DUP: begin
                if (!is_empty && !is_full) begin
                    nos_d   = tos_q;
                    spill   = (count_q >= C2);
                    count_d = count_q + C1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_SWAP: begin
                if (count_q >= C2) begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_NOP: begin
            end
            default: begin
                // reserved encoding behaves as NOP
            end
        endcase
    end

    // TOS/NOS/count registers and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q   <= '0;
            nos_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            count_q <= count_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Deep array: spill NOS into slot count-2, clear slot count-3 when it is pulled up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDEEP; i++) begin
                deep_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NDEEP; i++) begin
                if (spill && (count_q == CW'(i + 2))) begin
                    deep_q[i] <= nos_q;
                end else if (fill && (count_q == CW'(i + 3))) begin
                    deep_q[i] <= '0;
                end
            end
        end
    end

    // ALU operand routing and status outputs
    always_comb begin
        operand_a = unary ? tos_q : nos_q;
        operand_b = tos_q;
        tos       = tos_q;
        count     = count_q;
        empty     = is_empty;
        full      = is_full;
        err       = err_q;
    end

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: directed scenarios plus randomized commands against a queue-based stack model.
module tb_operand_stack;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cmd;
    logic          unary;
    logic [31:0]   data_in;
    logic [31:0]   result_in;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [31:0]   tos;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue, last element is the top of stack
    logic [31:0] q[$];
    logic        m_err;

    operand_stack #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .unary     (unary),
        .data_in   (data_in),
        .result_in (result_in),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .tos       (tos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_tos();
        return (q.size() > 0) ? q[q.size() - 1] : 32'd0;
    endfunction

    function automatic logic [31:0] m_nos();
        return (q.size() > 1) ? q[q.size() - 2] : 32'd0;
    endfunction

    task automatic model_apply(input logic [2:0] c, input logic [31:0] d, input logic [31:0] r);
        logic [31:0] a;
        logic [31:0] b;
        case (c)
            3'd1: if (q.size() < DEPTH) q.push_back(d); else m_err = 1'b1;
            3'd2: if (q.size() >= 1) a = q.pop_back(); else m_err = 1'b1;
            3'd3: if (q.size() >= 2) begin a = q.pop_back(); b = q.pop_back(); q.push_back(r); end
                  else m_err = 1'b1;
            3'd4: if (q.size() >= 1) begin a = q.pop_back(); q.push_back(r); end else m_err = 1'b1;
            3'd5: if (q.size() >= 1 && q.size() < DEPTH) q.push_back(q[q.size() - 1]); else m_err = 1'b1;
            3'd6: if (q.size() >= 2) begin a = q.pop_back(); b = q.pop_back(); q.push_back(a); q.push_back(b); end
                  else m_err = 1'b1;
            default: ;
        endcase
    endtask

    // Issue one command for one cycle, then return to NOP with unary=0 so operand_a shows NOS
    task automatic do_cmd(input logic [2:0] c, input logic [31:0] d, input logic [31:0] r, input logic u);
        cmd = c; data_in = d; result_in = r; unary = u;
        @(posedge clk);
        #1;
        model_apply(c, d, r);
        cmd = 3'd0; unary = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd = 3'd0; unary = 1'b0; data_in = '0; result_in = '0;
        q.delete(); m_err = 1'b0;
        #2;
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got %0d exp 0", count); end
        total++; if (tos !== 32'd0) begin bad++; $display("FAIL reset_tos got %h exp 0", tos); end
        total++; if ({empty, full, err} !== 3'b100) begin bad++; $display("FAIL reset_flags got %b exp 100", {empty, full, err}); end
        total++; if (operand_a !== 32'd0 || operand_b !== 32'd0) begin bad++; $display("FAIL reset_ops got a=%h b=%h exp 0", operand_a, operand_b); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_binop();
        apply_reset();
        do_cmd(3'd1, 32'd5, 32'd0, 1'b0);
        do_cmd(3'd1, 32'd3, 32'd0, 1'b0);
        cmd = 3'd3; result_in = 32'd2; unary = 1'b0;
        #1;
        total++; if (operand_a !== 32'd5 || operand_b !== 32'd3) begin bad++; $display("FAIL binop_operands got a=%0d b=%0d exp a=5 b=3", operand_a, operand_b); end
        do_cmd(3'd3, 32'd0, 32'd2, 1'b0);
        total++; if (count !== CW'(1) || tos !== 32'd2) begin bad++; $display("FAIL binop_result got count=%0d tos=%0d exp count=1 tos=2", count, tos); end
        total++; if (operand_a !== 32'd0 || err !== 1'b0) begin bad++; $display("FAIL binop_nos got nos=%0d err=%b exp nos=0 err=0", operand_a, err); end
    endtask

    task automatic test_unop();
        do_cmd(3'd1, 32'd7, 32'd0, 1'b0);
        cmd = 3'd4; result_in = 32'hFFFF_FFF9; unary = 1'b1;
        #1;
        total++; if (operand_a !== 32'd7) begin bad++; $display("FAIL unop_operand got %0d exp 7", operand_a); end
        do_cmd(3'd4, 32'd0, 32'hFFFF_FFF9, 1'b1);
        total++; if (tos !== 32'hFFFF_FFF9 || count !== CW'(2)) begin bad++; $display("FAIL unop_result got tos=%h count=%0d exp tos=fffffff9 count=2", tos, count); end
    endtask

    task automatic test_fill_drain();
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) do_cmd(3'd1, 32'(i), 32'd0, 1'b0);
        total++; if (full !== 1'b1 || tos !== 32'(DEPTH)) begin bad++; $display("FAIL fill_full got full=%b tos=%0d exp full=1 tos=%0d", full, tos, DEPTH); end
        do_cmd(3'd1, 32'd99, 32'd0, 1'b0);
        total++; if (err !== 1'b1 || tos !== 32'(DEPTH) || count !== CW'(DEPTH)) begin bad++; $display("FAIL push_overflow got err=%b tos=%0d count=%0d exp 1 %0d %0d", err, tos, count, DEPTH, DEPTH); end
        do_cmd(3'd5, 32'd0, 32'd0, 1'b0);
        total++; if (count !== CW'(DEPTH) || operand_a !== 32'(DEPTH - 1)) begin bad++; $display("FAIL dup_overflow got count=%0d nos=%0d exp %0d %0d", count, operand_a, DEPTH, DEPTH - 1); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (tos !== 32'(DEPTH - i)) begin bad++; $display("FAIL drain_order step %0d got %0d exp %0d", i, tos, DEPTH - i); end
            do_cmd(3'd2, 32'd0, 32'd0, 1'b0);
        end
        total++; if (empty !== 1'b1 || tos !== 32'd0 || count !== '0) begin bad++; $display("FAIL drain_empty got empty=%b tos=%0d count=%0d exp 1 0 0", empty, tos, count); end
    endtask

    task automatic test_swap_dup();
        apply_reset();
        do_cmd(3'd1, 32'hA, 32'd0, 1'b0);
        do_cmd(3'd1, 32'hB, 32'd0, 1'b0);
        do_cmd(3'd6, 32'd0, 32'd0, 1'b0);
        total++; if (tos !== 32'hA || operand_a !== 32'hB) begin bad++; $display("FAIL swap got tos=%h nos=%h exp a b", tos, operand_a); end
        do_cmd(3'd5, 32'd0, 32'd0, 1'b0);
        total++; if (count !== CW'(3) || tos !== 32'hA || operand_a !== 32'hA) begin bad++; $display("FAIL dup got count=%0d tos=%h nos=%h exp 3 a a", count, tos, operand_a); end
        do_cmd(3'd2, 32'd0, 32'd0, 1'b0);
        do_cmd(3'd2, 32'd0, 32'd0, 1'b0);
        total++; if (tos !== 32'hB || count !== CW'(1)) begin bad++; $display("FAIL dup_spill got tos=%h count=%0d exp b 1", tos, count); end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_cmd(3'd2, 32'd0, 32'd0, 1'b0);
        total++; if (err !== 1'b1 || count !== '0) begin bad++; $display("FAIL pop_underflow got err=%b count=%0d exp 1 0", err, count); end
        do_cmd(3'd1, 32'd4, 32'd0, 1'b0);
        do_cmd(3'd3, 32'd0, 32'd77, 1'b0);
        total++; if (err !== 1'b1 || count !== CW'(1) || tos !== 32'd4) begin bad++; $display("FAIL binop_underflow got err=%b count=%0d tos=%0d exp 1 1 4", err, count, tos); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_cmd(3'd1, 32'd11, 32'd0, 1'b0);
        do_cmd(3'd1, 32'd22, 32'd0, 1'b0);
        do_cmd(3'd1, 32'd33, 32'd0, 1'b0);
        // mid-cycle, with a PUSH pending
        cmd = 3'd1; data_in = 32'd44;
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== '0 || tos !== 32'd0 || operand_a !== 32'd0) begin bad++; $display("FAIL async_reset got count=%0d tos=%0d nos=%0d exp 0 0 0", count, tos, operand_a); end
        @(posedge clk); #1;
        total++; if (count !== '0 || empty !== 1'b1) begin bad++; $display("FAIL reset_wins got count=%0d empty=%b exp 0 1", count, empty); end
        cmd = 3'd0;
        rst = 1'b0;
        q.delete(); m_err = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [2:0] c;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(59) == 0) begin
                apply_reset();
            end
            // bias toward PUSH so the stack reaches deep and full states
            c = ($urandom_range(3) == 0) ? 3'd1 : 3'($urandom_range(7));
            do_cmd(c, $urandom, $urandom, 1'($urandom_range(1)));
            total++;
            if (count !== CW'(q.size()) || tos !== m_tos() || operand_a !== m_nos() || err !== m_err
                || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
                bad++;
                $display("FAIL random step %0d cmd %0d got count=%0d tos=%h nos=%h err=%b e/f=%b%b exp count=%0d tos=%h nos=%h err=%b",
                         n, c, count, tos, operand_a, err, empty, full, q.size(), m_tos(), m_nos(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_binop();
        test_unop();
        test_fill_drain();
        test_swap_dup();
        test_underflow();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
